// File: rtl/adpll_pkg.sv
// Shared ADPLL types and default sizing for the phase/frequency detector.
package adpll_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_LOCK_TH  = 2;
  localparam int DEF_LOCK_CNT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    LAG  = 2'd2
  } pfd_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Pin edge to rise_o pulse takes three clk edges.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q, rise_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/digital_pfd.sv
// Digital phase/frequency detector: measures ref-to-feedback edge spacing in clk cycles.
// Define PFD_LOCK_DET_EN to build the consecutive-in-lock detector; otherwise lock is 0.
module digital_pfd
  import adpll_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_TH  = DEF_LOCK_TH,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    UP,
  output logic                    DN,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    lock
);

  // Magnitude counter is one bit narrower so +/-cnt always fits the signed error.
  localparam logic [CNT_W-2:0] CNT_MAX = '1;
  localparam logic [CNT_W-2:0] CNT_ONE = (CNT_W-1)'(1);

  logic ref_rise, fb_rise;

  edge_sync u_ref_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (ref_in),
    .rise_o (ref_rise)
  );

  edge_sync u_fb_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (fb_in),
    .rise_o (fb_rise)
  );

  pfd_state_t              state_q, state_d;
  logic [CNT_W-2:0]        cnt_q, cnt_d;
  logic signed [CNT_W-1:0] phase_err_q, phase_err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    up_q, dn_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_err_d = phase_err_q;
    err_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          phase_err_d = '0;
          err_valid_d = 1'b1;
        end else if (ref_rise) begin
          state_d = LEAD;
          cnt_d   = CNT_ONE;
        end else if (fb_rise) begin
          state_d = LAG;
          cnt_d   = CNT_ONE;
        end
      end
      LEAD: begin
        // Extra ref edges mean a frequency error: keep counting rather than restart.
        if (fb_rise) begin
          state_d     = IDLE;
          phase_err_d = $signed({1'b0, cnt_q});
          err_valid_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LAG: begin
        if (ref_rise) begin
          state_d     = IDLE;
          phase_err_d = -$signed({1'b0, cnt_q});
          err_valid_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_err_q <= phase_err_d;
      err_valid_q <= err_valid_d;
      up_q        <= (state_d == LEAD);
      dn_q        <= (state_d == LAG);
    end
  end

  assign UP        = up_q;
  assign DN        = dn_q;
  assign phase_err = phase_err_q;
  assign err_valid = err_valid_q;

`ifdef PFD_LOCK_DET_EN
  localparam int                      LW         = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0]           LOCK_CNT_C = LW'(LOCK_CNT);
  localparam logic signed [CNT_W-1:0] LOCK_TH_C  = CNT_W'(LOCK_TH);

  logic [LW-1:0]           lock_cnt_q, lock_cnt_d;
  logic signed [CNT_W-1:0] err_abs;
  logic                    lock_q;

  // Work on the next-state error so lock moves in the same cycle as err_valid.
  assign err_abs = phase_err_d[CNT_W-1] ? -phase_err_d : phase_err_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (err_valid_d) begin
      if (err_abs > LOCK_TH_C) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_CNT_C) begin
        lock_cnt_d = lock_cnt_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= (lock_cnt_d == LOCK_CNT_C);
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_digital_pfd.sv
// Self-checking bench for digital_pfd against a timestamp-based reference model.
// Lock expectations follow PFD_LOCK_DET_EN when the bench is built with it.
module tb_digital_pfd;

  localparam int CNT_W    = 8;
  localparam int LOCK_TH  = 2;
  localparam int LOCK_CNT = 16;
  localparam int SAT      = (1 << (CNT_W - 1)) - 1;

  logic                    clk = 1'b0;
  logic                    reset, ref_in, fb_in;
  logic                    UP, DN, err_valid, lock;
  logic signed [CNT_W-1:0] phase_err;

  digital_pfd #(
    .CNT_W    (CNT_W),
    .LOCK_TH  (LOCK_TH),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .UP        (UP),
    .DN        (DN),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .lock      (lock)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: pin history, open-measurement side and its start edge.
  bit ref_h[5];
  bit fb_h[5];
  int side;       // 0 none, 1 ref edge seen first, 2 fb edge seen first
  int start_e;
  int edge_no = 0;
  int exp_err;
  bit exp_ev;
  int lock_run;
  bit exp_lock;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int abs_i(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic emit(input int e);
    exp_err  = e;
    exp_ev   = 1'b1;
    lock_run = (abs_i(e) <= LOCK_TH) ? min_i(lock_run + 1, LOCK_CNT) : 0;
`ifdef PFD_LOCK_DET_EN
    exp_lock = (lock_run >= LOCK_CNT);
`else
    exp_lock = 1'b0;
`endif
  endtask

  task automatic model_edge(input bit r, input bit f, input bit rst);
    bit rr, fr;
    edge_no++;
    exp_ev = 1'b0;
    if (rst) begin
      foreach (ref_h[i]) begin
        ref_h[i] = 1'b0;
        fb_h[i]  = 1'b0;
      end
      side     = 0;
      exp_err  = 0;
      lock_run = 0;
      exp_lock = 1'b0;
      return;
    end
    for (int i = 4; i > 0; i--) begin
      ref_h[i] = ref_h[i-1];
      fb_h[i]  = fb_h[i-1];
    end
    ref_h[0] = r;
    fb_h[0]  = f;
    // A pin rise reaches the decision logic three edges after it is sampled.
    rr = ref_h[3] && !ref_h[4];
    fr = fb_h[3] && !fb_h[4];
    case (side)
      0: begin
        if (rr && fr) emit(0);
        else if (rr) begin side = 1; start_e = edge_no; end
        else if (fr) begin side = 2; start_e = edge_no; end
      end
      1: if (fr) begin emit(min_i(edge_no - start_e, SAT)); side = 0; end
      2: if (rr) begin emit(-min_i(edge_no - start_e, SAT)); side = 0; end
      default: side = 0;
    endcase
  endtask

  task automatic step(input bit r, input bit f, input bit rst);
    @(negedge clk);
    ref_in = r;
    fb_in  = f;
    reset  = rst;
    @(posedge clk);
    model_edge(r, f, rst);
    #1;
    check("up", int'(UP), int'(side == 1));
    check("dn", int'(DN), int'(side == 2));
    check("up_dn_excl", int'(UP & DN), 0);
    check("err_valid", int'(err_valid), int'(exp_ev));
    check("phase_err", int'(phase_err), exp_err);
    check("lock", int'(lock), int'(exp_lock));
  endtask

  // One ref/fb rise pair; positive d means ref rises d cycles before fb.
  task automatic pair(input int d);
    int ra, fa, span;
    ra   = (d < 0) ? -d : 0;
    fa   = (d > 0) ? d : 0;
    span = abs_i(d) + 3;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= span; i++) step(i >= ra, i >= fa, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit r, f;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    pair(5);
    pair(-3);
    pair(0);

    // ref toggling with fb silent: count must saturate, then fb closes it.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

    // Reset mid-LEAD with ref held high through release, then fb closes.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);

    // Sixteen small errors, one large, then recovery.
    for (int i = 0; i < LOCK_CNT; i++) pair(($urandom_range(0, 1) == 0) ? 1 : -2);
    pair(2);
    pair(3);
    for (int i = 0; i < 4; i++) pair(-1);

    for (int i = 0; i < 30; i++) pair(int'($urandom_range(0, 24)) - 12);

    // Unstructured pin activity with occasional resets.
    r = 1'b0;
    f = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = ~r;
      if ($urandom_range(0, 4) == 0) f = ~f;
      step(r, f, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
